// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster timing generator. Two free-running counters walk the
// raster (hcount across a line, vcount down the frame). Sync and blank flags,
// line/frame pulses and a frame counter are decoded from those counts. The
// defaults give 1024x768@60 with a 65 MHz pixel clock.
//
// This block sits at the front of the video pipeline. Every output comes from
// the same flop stage, so hcount/vcount and their flags are aligned with zero
// relative latency. The decode is done on the *next* counts and registered
// together with the counts.
//
// Ports
//   clk          in   1        pixel clock
//   rst_n        in   1        asynchronous reset, active-low
//   en           in   1        pixel enable; nothing changes on edges with en=0
//   hcount       out  CNT_W    current pixel in line   (0 .. H_TOTAL-1)
//   vcount       out  CNT_W    current line in frame   (0 .. V_TOTAL-1)
//   hsync        out  1        horizontal sync, active level = HSYNC_POL
//   vsync        out  1        vertical sync,   active level = VSYNC_POL
//   hblnk        out  1        1 while hcount >= H_ACTIVE
//   vblnk        out  1        1 while vcount >= V_ACTIVE
//   line_start   out  1        one-enable pulse: hcount just wrapped to 0
//   frame_start  out  1        one-enable pulse: counters just wrapped to (0,0)
//   frame_cnt    out  FRAME_W  completed frames since reset, modulo 2^FRAME_W
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE     = 1024,
  parameter int H_SYNC_START = 1048,
  parameter int H_SYNC_STOP  = 1184,
  parameter int H_TOTAL      = 1344,
  parameter int V_ACTIVE     = 768,
  parameter int V_SYNC_START = 771,
  parameter int V_SYNC_STOP  = 777,
  parameter int V_TOTAL      = 806,
  parameter bit HSYNC_POL    = 1'b0,
  parameter bit VSYNC_POL    = 1'b0,
  parameter int CNT_W        = 11,
  parameter int FRAME_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic [CNT_W-1:0]   hcount,
  output logic [CNT_W-1:0]   vcount,
  output logic               hsync,
  output logic               vsync,
  output logic               hblnk,
  output logic               vblnk,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  // The counters are compared in a 32-bit unsigned domain below. That keeps a
  // sync window ending exactly at 2^CNT_W from aliasing to zero, so CNT_W must
  // stay below 32.
  if (CNT_W < 1 || CNT_W > 31) begin : g_bad_cnt_w
    $error("vga_timing_gen: CNT_W=%0d out of range 1..31", CNT_W);
  end

  if (FRAME_W < 1) begin : g_bad_frame_w
    $error("vga_timing_gen: FRAME_W=%0d must be >= 1", FRAME_W);
  end

  if (!(0 < H_ACTIVE && H_ACTIVE <= H_SYNC_START && H_SYNC_START < H_SYNC_STOP &&
        H_SYNC_STOP <= H_TOTAL)) begin : g_bad_h_order
    $error("vga_timing_gen: horizontal timing must satisfy 0<ACTIVE<=SYNC_START<SYNC_STOP<=TOTAL");
  end

  if (!(0 < V_ACTIVE && V_ACTIVE <= V_SYNC_START && V_SYNC_START < V_SYNC_STOP &&
        V_SYNC_STOP <= V_TOTAL)) begin : g_bad_v_order
    $error("vga_timing_gen: vertical timing must satisfy 0<ACTIVE<=SYNC_START<SYNC_STOP<=TOTAL");
  end

  if (longint'(H_TOTAL) > (longint'(1) << CNT_W) ||
      longint'(V_TOTAL) > (longint'(1) << CNT_W)) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W=%0d bits", CNT_W);
  end

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  // The wrap points are sized to the counter width so the equality compare is
  // exact. H_TOTAL-1 always fits once the checks above hold.
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // The window bounds are kept as unsigned 32-bit values. A bound equal to
  // 2^CNT_W (for example H_SYNC_STOP == H_TOTAL == 2^CNT_W) is still
  // represented correctly.
  localparam int unsigned H_ACT_U   = unsigned'(H_ACTIVE);
  localparam int unsigned H_SSTA_U  = unsigned'(H_SYNC_START);
  localparam int unsigned H_SSTO_U  = unsigned'(H_SYNC_STOP);
  localparam int unsigned V_ACT_U   = unsigned'(V_ACTIVE);
  localparam int unsigned V_SSTA_U  = unsigned'(V_SYNC_START);
  localparam int unsigned V_SSTO_U  = unsigned'(V_SYNC_STOP);

  // ---------------------------------------------------------------------------
  // Next-state counters and decode
  // ---------------------------------------------------------------------------
  logic               h_wrap;
  logic               v_wrap;
  logic [CNT_W-1:0]   hcount_n;
  logic [CNT_W-1:0]   vcount_n;
  int unsigned        hcount_nu;
  int unsigned        vcount_nu;
  logic               hsync_n;
  logic               vsync_n;
  logic               hblnk_n;
  logic               vblnk_n;
  logic               line_start_n;
  logic               frame_start_n;
  logic [FRAME_W-1:0] frame_cnt_n;

  // NOTE: every signal driven here gets a value on every path through the
  // block (straight-line code or a full ternary). This keeps the block free of
  // inferred latches.
  always_comb begin
    h_wrap   = (hcount == H_LAST);
    v_wrap   = (vcount == V_LAST);

    hcount_n = h_wrap ? '0 : hcount + CNT_W'(1);

    // vcount only moves on the edge where hcount wraps.
    if (h_wrap) begin
      vcount_n = v_wrap ? '0 : vcount + CNT_W'(1);
    end else begin
      vcount_n = vcount;
    end

    hcount_nu = 32'(hcount_n);
    vcount_nu = 32'(vcount_n);

    // The decode uses the next counts, so each flag lands in the same
    // register stage as the count it describes.
    hblnk_n = (hcount_nu >= H_ACT_U);
    vblnk_n = (vcount_nu >= V_ACT_U);

    hsync_n = ((hcount_nu >= H_SSTA_U) && (hcount_nu < H_SSTO_U)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_n = ((vcount_nu >= V_SSTA_U) && (vcount_nu < V_SSTO_U)) ? VSYNC_POL : ~VSYNC_POL;

    // The pulses are derived from the advanced counts and not from the
    // current ones. That is why reset release, which sits at (0,0), does not
    // produce a spurious pulse.
    line_start_n  = h_wrap;
    frame_start_n = h_wrap && v_wrap;
    frame_cnt_n   = frame_start_n ? frame_cnt + FRAME_W'(1) : frame_cnt;
  end

  // ---------------------------------------------------------------------------
  // Output register stage
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with non-blocking (<=) only. All flops
  // then sample their inputs from before the edge, and simulation matches the
  // synthesised registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else if (en) begin
      // With en low nothing loads. The pulses therefore stay high until the
      // next enabled edge, so a downstream stage running on the same enable
      // sees exactly one pulse.
      hcount      <= hcount_n;
      vcount      <= vcount_n;
      hsync       <= hsync_n;
      vsync       <= vsync_n;
      hblnk       <= hblnk_n;
      vblnk       <= vblnk_n;
      line_start  <= line_start_n;
      frame_start <= frame_start_n;
      frame_cnt   <= frame_cnt_n;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Self-checking bench for vga_timing_gen. It instantiates two copies:
//   dut_def : default 1024x768 timing, active-low syncs, one full line scanned
//   dut_sm  : tiny raster (H 4/5/6/8, V 3/4/5/6, active-high syncs, CNT_W=4,
//             FRAME_W=2). It is small enough to trace whole frames against a
//             reference model and to watch frame_cnt wrap.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic en_def;
  logic en_sm;

  always #5 clk = ~clk;

  // Default instance
  logic [10:0] hc_d, vc_d;
  logic        hs_d, vs_d, hb_d, vb_d, ls_d, fs_d;
  logic [15:0] fc_d;

  vga_timing_gen dut_def (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en_def),
    .hcount      (hc_d),
    .vcount      (vc_d),
    .hsync       (hs_d),
    .vsync       (vs_d),
    .hblnk       (hb_d),
    .vblnk       (vb_d),
    .line_start  (ls_d),
    .frame_start (fs_d),
    .frame_cnt   (fc_d)
  );

  // Small instance
  logic [3:0] hc_s, vc_s;
  logic       hs_s, vs_s, hb_s, vb_s, ls_s, fs_s;
  logic [1:0] fc_s;

  vga_timing_gen #(
    .H_ACTIVE     (4),
    .H_SYNC_START (5),
    .H_SYNC_STOP  (6),
    .H_TOTAL      (8),
    .V_ACTIVE     (3),
    .V_SYNC_START (4),
    .V_SYNC_STOP  (5),
    .V_TOTAL      (6),
    .HSYNC_POL    (1'b1),
    .VSYNC_POL    (1'b1),
    .CNT_W        (4),
    .FRAME_W      (2)
  ) dut_sm (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en_sm),
    .hcount      (hc_s),
    .vcount      (vc_s),
    .hsync       (hs_s),
    .vsync       (vs_s),
    .hblnk       (hb_s),
    .vblnk       (vb_s),
    .line_start  (ls_s),
    .frame_start (fs_s),
    .frame_cnt   (fc_s)
  );

  // Packed snapshot of the small instance's outputs (16 bits).
  typedef struct packed {
    logic [3:0] h;
    logic [3:0] v;
    logic       hs;
    logic       vs;
    logic       hb;
    logic       vb;
    logic       ls;
    logic       fs;
    logic [1:0] fc;
  } out_t;

  typedef struct {
    logic en;
    out_t exp;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic out_t sm_out();
    out_t o;
    o.h  = hc_s;
    o.v  = vc_s;
    o.hs = hs_s;
    o.vs = vs_s;
    o.hb = hb_s;
    o.vb = vb_s;
    o.ls = ls_s;
    o.fs = fs_s;
    o.fc = fc_s;
    return o;
  endfunction

  function automatic out_t mo(input int h, input int v, input bit hs, input bit vs,
                              input bit hb, input bit vb, input bit ls, input bit fs,
                              input int fc);
    out_t o;
    o.h  = 4'(h);
    o.v  = 4'(v);
    o.hs = hs;
    o.vs = vs;
    o.hb = hb;
    o.vb = vb;
    o.ls = ls;
    o.fs = fs;
    o.fc = 2'(fc);
    return o;
  endfunction

  // Reference model for the small raster: state after one enabled edge.
  function automatic out_t adv(input out_t m);
    out_t r;
    r.h  = (m.h == 4'd7) ? 4'd0 : m.h + 4'd1;
    if (m.h == 4'd7) r.v = (m.v == 4'd5) ? 4'd0 : m.v + 4'd1;
    else             r.v = m.v;
    r.hb = (r.h >= 4'd4);
    r.hs = (r.h == 4'd5);
    r.vb = (r.v >= 4'd3);
    r.vs = (r.v == 4'd4);
    r.ls = (r.h == 4'd0);
    r.fs = (r.h == 4'd0) && (r.v == 4'd0);
    r.fc = r.fs ? m.fc + 2'd1 : m.fc;
    return r;
  endfunction

  // One clock edge; outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en_sm = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam out_t SM_RST = '0;

  vec_t vecs[12];
  out_t m;
  int   hs_low;
  int   hb_hi;
  int   n_en;

  initial begin
    rst_n  = 1'b0;
    en_def = 1'b0;
    en_sm  = 1'b0;
    #12;

    // ---- Reset values of both instances --------------------------------
    check("rst_sm_all",   64'(sm_out()), 64'(SM_RST));
    check("rst_def_h",    64'(hc_d), 64'd0);
    check("rst_def_v",    64'(vc_d), 64'd0);
    check("rst_def_hs",   64'(hs_d), 64'd1);
    check("rst_def_vs",   64'(vs_d), 64'd1);
    check("rst_def_flag", 64'({hb_d, vb_d, ls_d, fs_d}), 64'd0);
    check("rst_def_fc",   64'(fc_d), 64'd0);

    // ---- Default timing: one full line ---------------------------------
    @(negedge clk);
    rst_n  = 1'b1;
    en_def = 1'b1;
    hs_low = 0;
    hb_hi  = 0;
    for (int i = 1; i <= 1344; i++) begin
      step();
      if (!hs_d) hs_low++;
      if (hb_d)  hb_hi++;
      case (i)
        1:    check("def_h_first", 64'(hc_d), 64'd1);
        1023: check("def_hb_1023", 64'({hc_d, hb_d}), 64'({11'd1023, 1'b0}));
        1024: check("def_hb_1024", 64'({hc_d, hb_d}), 64'({11'd1024, 1'b1}));
        1047: check("def_hs_1047", 64'(hs_d), 64'd1);
        1048: check("def_hs_1048", 64'(hs_d), 64'd0);
        1183: check("def_hs_1183", 64'(hs_d), 64'd0);
        1184: check("def_hs_1184", 64'(hs_d), 64'd1);
        1343: check("def_no_early_ls", 64'({hc_d, vc_d, ls_d}), 64'({11'd1343, 11'd0, 1'b0}));
        1344: check("def_line_wrap", 64'({hc_d, vc_d, ls_d, fs_d}), 64'({11'd0, 11'd1, 1'b1, 1'b0}));
        default: ;
      endcase
    end
    check("def_hsync_low_cnt", 64'(hs_low), 64'd136);
    check("def_hblnk_hi_cnt",  64'(hb_hi),  64'd320);
    check("def_vs_vb_line1",   64'({vs_d, vb_d, fc_d}), 64'({1'b1, 1'b0, 16'd0}));
    en_def = 1'b0;

    // ---- Small raster: hand-computed vectors, incl. en=0 holds ---------
    vecs[0]  = '{en: 1'b1, exp: mo(1, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[1]  = '{en: 1'b1, exp: mo(2, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[2]  = '{en: 1'b0, exp: mo(2, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[3]  = '{en: 1'b1, exp: mo(3, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[4]  = '{en: 1'b1, exp: mo(4, 0, 0, 0, 1, 0, 0, 0, 0)};
    vecs[5]  = '{en: 1'b1, exp: mo(5, 0, 1, 0, 1, 0, 0, 0, 0)};
    vecs[6]  = '{en: 1'b0, exp: mo(5, 0, 1, 0, 1, 0, 0, 0, 0)};
    vecs[7]  = '{en: 1'b1, exp: mo(6, 0, 0, 0, 1, 0, 0, 0, 0)};
    vecs[8]  = '{en: 1'b1, exp: mo(7, 0, 0, 0, 1, 0, 0, 0, 0)};
    vecs[9]  = '{en: 1'b1, exp: mo(0, 1, 0, 0, 0, 0, 1, 0, 0)};
    vecs[10] = '{en: 1'b0, exp: mo(0, 1, 0, 0, 0, 0, 1, 0, 0)};
    vecs[11] = '{en: 1'b1, exp: mo(1, 1, 0, 0, 0, 0, 0, 0, 0)};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      en_sm = vecs[i].en;
      step();
      check($sformatf("vec%0d", i), 64'(sm_out()), 64'(vecs[i].exp));
    end

    // ---- Small raster: 4 frames with random enable vs model ------------
    do_reset();
    m    = SM_RST;
    n_en = 0;
    for (int i = 0; n_en < 192; i++) begin
      en_sm = (i >= 3000) ? 1'b1 : 1'($urandom_range(0, 1));
      step();
      if (en_sm) begin
        m = adv(m);
        n_en++;
      end
      check($sformatf("trace%0d", i), 64'(sm_out()), 64'(m));
    end
    // The fourth frame_start wraps frame_cnt 3->0. The vcount wrap lands on
    // the same edge as frame_start.
    check("fc_wrap_4th_frame", 64'(sm_out()), 64'(mo(0, 0, 0, 0, 0, 0, 1, 1, 0)));

    // ---- Advance to (h=5,v=2) in frame 1, then reset mid-cycle ---------
    en_sm = 1'b1;
    for (int i = 0; i < 69; i++) begin
      step();
      m = adv(m);
      check($sformatf("pre_rst%0d", i), 64'(sm_out()), 64'(m));
    end
    check("pre_rst_state", 64'(sm_out()), 64'(mo(5, 2, 1, 0, 1, 0, 0, 0, 1)));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_sm", 64'(sm_out()), 64'(SM_RST));
    #1;
    rst_n = 1'b1;
    step();
    check("restart_first", 64'(sm_out()), 64'(mo(1, 0, 0, 0, 0, 0, 0, 0, 0)));
    for (int i = 0; i < 7; i++) step();
    check("restart_line", 64'(sm_out()), 64'(mo(0, 1, 0, 0, 0, 0, 1, 0, 0)));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
